reg_universal_n: RTL and testbench

REG_UNIVERSAL_N -- requirements
Module: reg_universal_n

---
 rtl/reg_universal_n.sv | 215 +++++++++++++++++++++
 tb/tb_reg_universal_n.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_universal_n.sv
// ---------------------------------------------------------------------------
// reg_universal_n -- universal shift/rotate/load register with an optional
// multi-step burst engine.
//
// Build option:
//   REG_UNIVERSAL_BURST_EN  defined   -> burst engine present (start/count,
//                                        busy/done active)
//                           undefined -> start/count ignored, busy/done tied 0
//
// Parameters:
//   WIDTH  register width in bits (>= 2)
//   CW     width of the burst count port
//
// Ports:
//   clk      rising-edge clock for all state
//   reset    asynchronous active-low reset, clears all state
//   set      synchronous, loads all ones (highest priority, ignores enable)
//   enable   high permits mode ops and burst progress, low holds all state
//   mode     000 hold, 001 shr, 010 shl, 011 load, 100 ror, 101 rol,
//            110 asr, 111 clear
//   P_in     parallel load data
//   S_in     serial bit: enters MSB on shr, LSB on shl
//   start    burst request
//   count    burst length in single-bit steps (clamped to WIDTH)
//   P_out    register contents
//   S_out_r  P_out[0]
//   S_out_l  P_out[WIDTH-1]
//   busy     high while a burst still has steps to apply
//   done     one-cycle pulse at burst completion
// ---------------------------------------------------------------------------
module reg_universal_n #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] P_in,
  input  logic             S_in,
  input  logic             start,
  input  logic [CW-1:0]    count,
  output logic [WIDTH-1:0] P_out,
  output logic             S_out_r,
  output logic             S_out_l,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHR   = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_LOAD  = 3'b011;
  localparam logic [2:0] MODE_ROR   = 3'b100;
  localparam logic [2:0] MODE_ROL   = 3'b101;
  localparam logic [2:0] MODE_ASR   = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  // One register step for the given op.
  function automatic logic [WIDTH-1:0] step_f(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic             s_in,
    input logic [WIDTH-1:0] p_in
  );
    logic [WIDTH-1:0] res;
    case (op)
      MODE_HOLD:  res = cur;
      MODE_SHR:   res = {s_in, cur[WIDTH-1:1]};
      MODE_SHL:   res = {cur[WIDTH-2:0], s_in};
      MODE_LOAD:  res = p_in;
      MODE_ROR:   res = {cur[0], cur[WIDTH-1:1]};
      MODE_ROL:   res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ASR:   res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      MODE_CLEAR: res = {WIDTH{1'b0}};
      default:    res = cur;
    endcase
    return res;
  endfunction

  logic [WIDTH-1:0] p_out_r;
  logic [WIDTH-1:0] p_next_s;

  assign P_out   = p_out_r;
  assign S_out_r = p_out_r[0];
  assign S_out_l = p_out_r[WIDTH-1];

`ifdef REG_UNIVERSAL_BURST_EN

  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] ZERO_C  = CW'(0);

  // Only single-bit movement ops may be repeated as a burst.
  function automatic logic is_burst_mode_f(input logic [2:0] op);
    logic ok;
    case (op)
      MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR: ok = 1'b1;
      default:                                          ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic          busy_r;
  logic          done_r;
  logic [2:0]    burst_mode_r;
  logic [CW-1:0] remaining_r;

  logic          busy_next_s;
  logic          done_next_s;
  logic [2:0]    burst_mode_next_s;
  logic [CW-1:0] remaining_next_s;
  logic          start_ok_s;
  logic [CW-1:0] start_len_s;

  assign busy = busy_r;
  assign done = done_r;

  assign start_ok_s  = start & enable & ~busy_r & ~set & is_burst_mode_f(mode);
  assign start_len_s = (count > WIDTH_C) ? WIDTH_C : count;

  // Next-state selection: set > active burst > start acceptance > single op.
  // remaining_r counts the steps still owed after the current edge, so the
  // accepting edge already consumes one step.
  always_comb begin
    p_next_s          = p_out_r;
    busy_next_s       = busy_r;
    done_next_s       = 1'b0;
    remaining_next_s  = remaining_r;
    burst_mode_next_s = burst_mode_r;
    if (set) begin
      p_next_s          = {WIDTH{1'b1}};
      busy_next_s       = 1'b0;
      remaining_next_s  = ZERO_C;
      burst_mode_next_s = MODE_HOLD;
    end else if (!enable) begin
      p_next_s = p_out_r;
    end else if (busy_r) begin
      p_next_s         = step_f(burst_mode_r, p_out_r, S_in, P_in);
      remaining_next_s = remaining_r - ONE_C;
      if (remaining_r == ONE_C) begin
        busy_next_s = 1'b0;
        done_next_s = 1'b1;
      end else begin
        busy_next_s = 1'b1;
      end
    end else if (start_ok_s) begin
      burst_mode_next_s = mode;
      if (start_len_s == ZERO_C) begin
        // Zero-length burst: nothing moves, completion is reported at once.
        remaining_next_s = ZERO_C;
        busy_next_s      = 1'b0;
        done_next_s      = 1'b1;
      end else begin
        p_next_s         = step_f(mode, p_out_r, S_in, P_in);
        remaining_next_s = start_len_s - ONE_C;
        busy_next_s      = (start_len_s != ONE_C);
        done_next_s      = (start_len_s == ONE_C);
      end
    end else begin
      p_next_s = step_f(mode, p_out_r, S_in, P_in);
    end
  end

  // State registers for the data word and the burst engine.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_out_r      <= {WIDTH{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      remaining_r  <= ZERO_C;
      burst_mode_r <= MODE_HOLD;
    end else begin
      p_out_r      <= p_next_s;
      busy_r       <= busy_next_s;
      done_r       <= done_next_s;
      remaining_r  <= remaining_next_s;
      burst_mode_r <= burst_mode_next_s;
    end
  end

`else

  // Burst request inputs have no function in this build.
  logic unused_s;
  assign unused_s = ^{start, count};

  assign busy = 1'b0;
  assign done = 1'b0;

  // Next-state selection without the burst engine: set > single op.
  always_comb begin
    p_next_s = p_out_r;
    if (set) begin
      p_next_s = {WIDTH{1'b1}};
    end else if (enable) begin
      p_next_s = step_f(mode, p_out_r, S_in, P_in);
    end else begin
      p_next_s = p_out_r;
    end
  end

  // Data word register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_out_r <= {WIDTH{1'b0}};
    end else begin
      p_out_r <= p_next_s;
    end
  end

`endif

endmodule

// File: tb/tb_reg_universal_n.sv
// ---------------------------------------------------------------------------
// tb_reg_universal_n -- scoreboard bench for reg_universal_n (WIDTH=8).
// A driver applies one input set per clock at the falling edge, advances a
// behavioural model and queues the expected post-edge outputs; a monitor
// samples the DUT just after each rising edge and compares against the queue.
// ---------------------------------------------------------------------------
module tb_reg_universal_n;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         set;
  logic         enable;
  logic [2:0]   mode;
  logic [W-1:0] P_in;
  logic         S_in;
  logic         start;
  logic [3:0]   count;
  logic [W-1:0] P_out;
  logic         S_out_r;
  logic         S_out_l;
  logic         busy;
  logic         done;

  reg_universal_n #(.WIDTH(W), .CW(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .set     (set),
    .enable  (enable),
    .mode    (mode),
    .P_in    (P_in),
    .S_in    (S_in),
    .start   (start),
    .count   (count),
    .P_out   (P_out),
    .S_out_r (S_out_r),
    .S_out_l (S_out_l),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] p;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;

  // Model state: current word plus the list of burst steps still owed.
  logic [W-1:0] m_p = 8'h00;
  logic [2:0]   m_steps[$];

  function automatic logic [W-1:0] apply_op(input logic [2:0] m, input logic [W-1:0] p,
                                            input logic sin, input logic [W-1:0] pin);
    case (m)
      3'd1:    return (p >> 1) | (sin ? 8'h80 : 8'h00);
      3'd2:    return (p << 1) | {7'd0, sin};
      3'd3:    return pin;
      3'd4:    return (p >> 1) | (p << 7);
      3'd5:    return (p << 1) | (p >> 7);
      3'd6:    return (p >> 1) | (p & 8'h80);
      3'd7:    return 8'h00;
      default: return p;
    endcase
  endfunction

  function automatic bit repeatable(input logic [2:0] m);
    return (m == 3'd1) || (m == 3'd2) || (m == 3'd4) || (m == 3'd5) || (m == 3'd6);
  endfunction

  // Apply one set of inputs for the next rising edge and queue the expectation.
  task automatic drive(input logic s, input logic en, input logic [2:0] m,
                       input logic [W-1:0] pin, input logic sin, input logic st,
                       input logic [3:0] cnt);
    exp_t e;
    int   n;
    logic d;
    @(negedge clk);
    set = s; enable = en; mode = m; P_in = pin; S_in = sin; start = st; count = cnt;
    d = 1'b0;
    if (s) begin
      m_p = 8'hFF;
      m_steps.delete();
    end else if (!en) begin
      d = 1'b0;
`ifdef REG_UNIVERSAL_BURST_EN
    end else if (m_steps.size() > 0) begin
      m_p = apply_op(m_steps.pop_front(), m_p, sin, pin);
      d = (m_steps.size() == 0);
    end else if (st && repeatable(m)) begin
      n = (int'(cnt) > W) ? W : int'(cnt);
      if (n == 0) begin
        d = 1'b1;
      end else begin
        m_p = apply_op(m, m_p, sin, pin);
        for (int k = 1; k < n; k++) m_steps.push_back(m);
        d = (n == 1);
      end
`endif
    end else begin
      m_p = apply_op(m, m_p, sin, pin);
    end
    e.p    = m_p;
    e.busy = (m_steps.size() > 0);
    e.done = d;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(1'b0, 1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0);
  endtask

  // Direct check of the cleared state while reset is (or was just) asserted.
  task automatic check_cleared(input string name);
    vectors++;
    if (P_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got P_out=%h busy=%b done=%b, want P_out=00 busy=0 done=0",
               name, P_out, busy, done);
    end
  endtask

  // Monitor: compare every queued expectation just after its rising edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (P_out !== e.p || S_out_r !== e.p[0] || S_out_l !== e.p[W-1] ||
            busy !== e.busy || done !== e.done) begin
          miscompares++;
          $display("FAIL edge @%0t: got P_out=%h S_out_r=%b S_out_l=%b busy=%b done=%b, want P_out=%h S_out_r=%b S_out_l=%b busy=%b done=%b",
                   $time, P_out, S_out_r, S_out_l, busy, done,
                   e.p, e.p[0], e.p[W-1], e.busy, e.done);
        end
      end
    end
  end

  initial begin : stimulus
    reset = 1'b0; set = 1'b0; enable = 1'b0; mode = 3'b000; P_in = 8'h00;
    S_in = 1'b0; start = 1'b0; count = 4'd0;
    #12;
    check_cleared("reset_state");
    @(negedge clk);
    reset = 1'b1;

    // Load 0xA5, then an asynchronous reset in the middle of a cycle.
    drive(1'b0, 1'b1, 3'b011, 8'hA5, 1'b0, 1'b0, 4'd0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_cleared("async_reset");
    m_p = 8'h00;
    m_steps.delete();
    enable = 1'b0; start = 1'b0; set = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Single-op corner cases.
    drive(1'b0, 1'b1, 3'b011, 8'h81, 1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 3'b100, 8'h00, 1'b1, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 3'b011, 8'h80, 1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 3'b011, 8'h80, 1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 1'b0, 4'd0);

    // rol burst of 3 from 0x01; mode/start/count during the burst are ignored.
    drive(1'b0, 1'b1, 3'b011, 8'h01, 1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 1'b1, 4'd3);
    drive(1'b0, 1'b1, 3'b111, 8'h55, 1'b1, 1'b1, 4'd9);
    drive(1'b0, 1'b1, 3'b011, 8'hAA, 1'b0, 1'b0, 4'd0);
    idle(2);

    // shr burst of 4 from 0xF0 with a two-cycle enable pause after step 2.
    drive(1'b0, 1'b1, 3'b011, 8'hF0, 1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 3'b001, 8'h00, 1'b0, 1'b1, 4'd4);
    drive(1'b0, 1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b0, 3'b011, 8'hFF, 1'b1, 1'b1, 4'd2);
    drive(1'b0, 1'b0, 3'b111, 8'hFF, 1'b1, 1'b0, 4'd2);
    idle(3);

    // set aborts a burst; then a zero-length burst.
    drive(1'b0, 1'b1, 3'b011, 8'h3C, 1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 3'b001, 8'h00, 1'b1, 1'b1, 4'd5);
    drive(1'b0, 1'b1, 3'b000, 8'h00, 1'b1, 1'b0, 4'd0);
    drive(1'b1, 1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0);
    idle(2);
    drive(1'b0, 1'b1, 3'b011, 8'h5A, 1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 3'b001, 8'h00, 1'b1, 1'b1, 4'd0);
    idle(2);

    // count above WIDTH clamps: rol 15 from 0x01 returns to 0x01.
    drive(1'b0, 1'b1, 3'b011, 8'h01, 1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 1'b1, 4'd15);
    idle(9);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 24) == 0,
            $urandom_range(0, 4) != 0,
            3'($urandom_range(0, 7)),
            8'($urandom),
            1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0,
            4'($urandom_range(0, 15)));
    end
    idle(2);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d expectations left, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
